// File: rtl/rv32_pkg.sv
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 execute-stage definitions: M-extension funct3
//                encodings, the M-extension funct7 value used by the decoder
//                that raises start, and the multiply/divide sequencer state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  // funct3 operation select for OP with funct7 == M_EXT
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // funct7 identifying the M extension
  localparam logic [6:0] M_EXT = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } muldiv_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. 32-step shift-add
//                multiply and restoring divide on operand magnitudes, with a
//                final sign fix-up. Divide-by-zero and signed overflow resolve
//                at accept and complete in one cycle. A kill aborts any
//                operation in flight without a done pulse.
//  Ports       : clk, rst (async, active-high)
//                start, funct3, data_rs1, data_rs2, rd_in : request
//                kill                                     : pipeline flush
//                ready, busy                              : sequencer status
//                done, result, rd_out                     : completion
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  import rv32_pkg::*;

  localparam int                CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t r_state;
  muldiv_state_t w_state_next;

  logic [2*XLEN-1:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_opb;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd_lat;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  // ---------------------------------------------------------------------------
  // Accept-time decode: signedness, magnitudes, negate flag, special cases
  // ---------------------------------------------------------------------------
  logic            w_rs1_signed, w_rs2_signed;
  logic            w_neg1, w_neg2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_is_div;
  logic            w_div_by_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_neg_flag;
  logic            w_accept;

  assign w_rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                        (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_rs2_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                        (funct3 == F3_REM);

  assign w_neg1 = w_rs1_signed & data_rs1[XLEN-1];
  assign w_neg2 = w_rs2_signed & data_rs2[XLEN-1];
  assign w_mag1 = w_neg1 ? (~data_rs1 + 1'b1) : data_rs1;
  assign w_mag2 = w_neg2 ? (~data_rs2 + 1'b1) : data_rs2;

  assign w_is_div      = funct3[2];
  assign w_div_by_zero = w_is_div && (data_rs2 == '0);
  assign w_div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                         (data_rs1 == MOST_NEG) && (data_rs2 == '1);
  assign w_special     = w_div_by_zero | w_div_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_div_by_zero)
      w_special_res = funct3[1] ? data_rs1 : '1;
    else if (w_div_ovf)
      w_special_res = funct3[1] ? '0 : MOST_NEG;
  end

  // Quotient/high product take the XOR of signs; remainder follows the dividend.
  always_comb begin
    w_neg_flag = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV:   w_neg_flag = w_neg1 ^ w_neg2;
      F3_MULHSU, F3_REM: w_neg_flag = w_neg1;
      default:           w_neg_flag = 1'b0;
    endcase
  end

  assign w_accept = (r_state == IDLE) && start && !kill;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shrem;
  logic [XLEN:0]     w_diff;
  logic              w_borrow;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_step_next;
  logic              w_last;

  // Add into the upper half with a carry bit, then shift the 65-bit value right.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // Shifted remainder needs XLEN+1 bits; an extra top bit captures the borrow.
  assign w_shrem               = r_acc[2*XLEN-1:XLEN-1];
  assign {w_borrow, w_diff}    = {1'b0, w_shrem} - {2'b00, r_opb};
  assign w_div_next = {(w_borrow ? w_shrem[XLEN-1:0] : w_diff[XLEN-1:0]),
                       r_acc[XLEN-2:0], ~w_borrow};

  assign w_step_next = (r_state == DIV) ? w_div_next : w_mul_next;
  assign w_last      = (r_cnt == LAST_STEP);

  // A committed difference is always below the divisor, so its top bit is zero.
  logic w_unused_diff_msb;
  assign w_unused_diff_msb = w_diff[XLEN];

  // ---------------------------------------------------------------------------
  // Final sign fix-up and word select, evaluated on the last iteration
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res, w_div_raw, w_div_res, w_final;

  assign w_prod    = r_neg ? (~w_mul_next + 1'b1) : w_mul_next;
  assign w_mul_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_raw = r_f3[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
  assign w_div_res = r_neg ? (~w_div_raw + 1'b1) : w_div_raw;
  assign w_final   = (r_state == DIV) ? w_div_res : w_mul_res;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !kill)
          w_state_next = w_special ? FIN : (w_is_div ? DIV : MUL);
      end
      MUL, DIV: begin
        if (kill)
          w_state_next = IDLE;
        else if (w_last)
          w_state_next = FIN;
      end
      FIN: begin
        done         = !kill;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_rd_lat <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (w_accept) begin
      r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
      r_opb    <= w_is_div ? w_mag2 : w_mag1;
      r_cnt    <= '0;
      r_f3     <= funct3;
      r_rd_lat <= rd_in;
      r_neg    <= w_neg_flag;
      if (w_special) begin
        r_result <= w_special_res;
        r_rd_out <= rd_in;
      end
    end else if (((r_state == MUL) || (r_state == DIV)) && !kill) begin
      r_acc <= w_step_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_final;
        r_rd_out <= r_rd_lat;
      end
    end
  end

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state != IDLE);
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq. Directed RV32M cases,
//                randomized operations against an arithmetic reference model,
//                kill/abort, ignored start while busy, and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] data_rs1 = 32'd0;
  logic [31:0] data_rs2 = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = 32'd0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .data_rs1 (data_rs1),
    .data_rs2 (data_rs2),
    .rd_in    (rd_in),
    .kill     (kill),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  // Architectural RV32M result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, t;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = '0;
    case (f3)
      F3_MUL:    t = ua * ub;
      F3_MULH:   t = (sa * sb) >>> 32;
      F3_MULHSU: t = (sa * ub) >>> 32;
      F3_MULHU:  t = (ua * ub) >> 32;
      F3_DIV: begin
        if (b == 32'd0) t = -64'sd1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = ua;
        else t = sa / sb;
      end
      F3_DIVU:   t = (b == 32'd0) ? -64'sd1 : ua / ub;
      F3_REM: begin
        if (b == 32'd0) t = ua;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = '0;
        else t = sa % sb;
      end
      default:   t = (b == 32'd0) ? ua : ua % ub;
    endcase
    return t[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
           (((f3 == F3_DIV) || (f3 == F3_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one operation from a negedge and follow it to completion.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noise, input string tag);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    bit          seen;
    exp     = ref_model(f3, a, b);
    exp_lat = is_special(f3, a, b) ? 1 : 33;
    for (int w = 0; w < 40 && ready !== 1'b1; w++) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_issue: got %b expected 1", tag, ready);
    end
    funct3 = f3; data_rs1 = a; data_rs2 = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
      if (noise) begin
        start    = 1'b1;
        funct3   = 3'($urandom);
        data_rs1 = $urandom;
        data_rs2 = $urandom;
        rd_in    = 5'($urandom);
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 60 cycles, expected after %0d", tag, exp_lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
      end
      checks++;
      if (result !== exp) begin
        errors++;
        $display("FAIL %s result: f3=%0d a=%h b=%h got %h expected %h", tag, f3, a, b, result, exp);
      end
      checks++;
      if (rd_out !== rd) begin
        errors++;
        $display("FAIL %s rd_out: got %0d expected %0d", tag, rd_out, rd);
      end
      last_exp = exp;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b ready=%b expected done=0 ready=1", tag, done, ready);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (result !== 32'd0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: result=%h rd_out=%0d expected 0 and 0", result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd11, 1'b0, "mul_7xm3");
    do_op(F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  1'b0, "mulh_min");
    do_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b0, "mulhu_max");
    do_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b0, "mulhsu_m1");
    do_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  1'b0, "div_m7_2");
    do_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd5,  1'b0, "rem_m7_2");
    do_op(F3_DIVU,   32'd100,        32'd7,         5'd6,  1'b0, "divu_100_7");
    do_op(F3_REMU,   32'd100,        32'd7,         5'd7,  1'b0, "remu_100_7");
    do_op(F3_DIV,    32'd5,          32'd0,         5'd8,  1'b0, "div_by0");
    do_op(F3_REM,    32'd5,          32'd0,         5'd9,  1'b0, "rem_by0");
    do_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1'b0, "div_ovf");
    do_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0, "rem_ovf");
  endtask

  task automatic test_kill();
    bit early_done;
    early_done = 1'b0;
    funct3 = F3_DIV; data_rs1 = 32'd123456; data_rs2 = 32'd77; rd_in = 5'd21; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) early_done = 1'b1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || early_done) begin
      errors++;
      $display("FAIL kill_abort: ready=%b early_done=%b expected ready=1 early_done=0", ready, early_done);
    end
    checks++;
    if (result !== last_exp) begin
      errors++;
      $display("FAIL kill_hold: result=%h expected %h", result, last_exp);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done === 1'b1) early_done = 1'b1;
    end
    checks++;
    if (early_done) begin
      errors++;
      $display("FAIL kill_no_done: got done=1 expected none");
    end
    do_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22, 1'b0, "mulhu_after_kill");
  endtask

  task automatic test_start_kill_idle();
    bit saw_done;
    saw_done = 1'b0;
    funct3 = F3_MUL; data_rs1 = 32'd3; data_rs2 = 32'd4; rd_in = 5'd30;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_kill_idle: ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || result !== last_exp) begin
      errors++;
      $display("FAIL start_kill_dropped: done_seen=%b result=%h expected no done, result %h",
               saw_done, result, last_exp);
    end
  endtask

  task automatic test_busy_ignore();
    do_op(F3_MUL,  32'h0001_2345, 32'h0000_6789, 5'd13, 1'b1, "busy_noise_mul");
    do_op(F3_DIVU, 32'hF000_0001, 32'h0000_0013, 5'd14, 1'b1, "busy_noise_divu");
  endtask

  task automatic test_reset_mid();
    funct3 = F3_MUL; data_rs1 = 32'h1111_1111; data_rs2 = 32'h2222_2222; rd_in = 5'd17; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_status: busy=%b done=%b ready=%b expected 0 0 1", busy, done, ready);
    end
    checks++;
    if (result !== 32'd0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: result=%h rd_out=%0d expected 0 and 0", result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'd0;
    @(negedge clk);
    do_op(F3_MULH, 32'hFFFF_0000, 32'h0001_0001, 5'd18, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      do_op(f3, a, b, 5'($urandom), (i % 4) == 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_start_kill_idle();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    // back-to-back: issue as soon as ready returns, mixing special and normal
    do_op(F3_DIVU, 32'd9,         32'd0, 5'd25, 1'b0, "b2b_special");
    do_op(F3_REMU, 32'd9,         32'd4, 5'd26, 1'b0, "b2b_normal");
    do_op(F3_MUL,  32'hFFFF_FFFF, 32'd2, 5'd27, 1'b0, "b2b_mul");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
